// File: rtl/tx_net_sched.sv
// tx_net_sched: frame-atomic arbiter of two frame sources onto the MAC tx port.
// Port 0 is paced by a signed token bucket; port 1 is never limited.
module tx_net_sched #(
    parameter int WIDTH     = 64,
    parameter int CREDIT_W  = 24,
    parameter int BASE_ADDR = 16
) (
    input  logic                         clk_net,
    input  logic                         rst,
    input  logic [WIDTH-1:0]             s0_tx_data,
    input  logic [$clog2(WIDTH/8)-1:0]   s0_tx_len,
    input  logic                         s0_tx_sof,
    input  logic                         s0_tx_eof,
    input  logic                         s0_tx_vld,
    output logic                         s0_tx_ack,
    input  logic [WIDTH-1:0]             s1_tx_data,
    input  logic [$clog2(WIDTH/8)-1:0]   s1_tx_len,
    input  logic                         s1_tx_sof,
    input  logic                         s1_tx_eof,
    input  logic                         s1_tx_vld,
    output logic                         s1_tx_ack,
    output logic [WIDTH-1:0]             tx_data_net,
    output logic [$clog2(WIDTH/8)-1:0]   tx_len_net,
    output logic                         tx_sof_net,
    output logic                         tx_eof_net,
    output logic                         tx_vld_net,
    input  logic                         tx_ack_net,
    input  logic                         reg_w_en,
    input  logic [10:0]                  reg_w_addr,
    input  logic [31:0]                  reg_w_data,
    input  logic                         reg_r_en,
    input  logic [10:0]                  reg_r_addr,
    output logic [31:0]                  reg_r_data,
    output logic                         reg_r_ack
);
    localparam int LW = $clog2(WIDTH/8);
    localparam int EW = CREDIT_W + 34;
    localparam logic signed [EW-1:0] CMAX = EW'((64'(1) << (CREDIT_W-1)) - 64'(1));
    localparam logic signed [EW-1:0] CMIN = -CMAX - EW'(1);

    typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;
    state_t state, nxt;

    logic last_gnt, cfg_en, cfg_prio, el0, el1, g0, g1, a0, a1, tick;
    logic [31:0] cfg_rate, cfg_period, cfg_burst, pcnt, per_m1, fcnt0, fcnt1, rmux;
    logic signed [CREDIT_W-1:0] credit;
    logic signed [EW-1:0] acc, capped, credit_d, burst_x;
    logic [LW:0] debit;
    logic [10:0] woff, roff;

    assign g0  = state == GNT0;
    assign g1  = state == GNT1;
    assign el0 = s0_tx_vld & s0_tx_sof & (~cfg_en | ~credit[CREDIT_W-1]);
    assign el1 = s1_tx_vld & s1_tx_sof;
    assign a0  = g0 & s0_tx_vld & tx_ack_net;
    assign a1  = g1 & s1_tx_vld & tx_ack_net;

    always_ff @(posedge clk_net or posedge rst)
        if (rst) state <= IDLE;
        else     state <= nxt;

    always_comb begin
        nxt = state;
        case (state)
            IDLE:    nxt = (el0 & el1) ? ((cfg_prio | ~last_gnt) ? GNT1 : GNT0)
                         : el1 ? GNT1 : el0 ? GNT0 : IDLE;
            GNT0:    nxt = (a0 & s0_tx_eof) ? IDLE : GNT0;
            GNT1:    nxt = (a1 & s1_tx_eof) ? IDLE : GNT1;
            default: nxt = IDLE;
        endcase
        tx_data_net = g0 ? s0_tx_data : g1 ? s1_tx_data : '0;
        tx_len_net  = g0 ? s0_tx_len  : g1 ? s1_tx_len  : '0;
        tx_sof_net  = g0 ? s0_tx_sof  : g1 & s1_tx_sof;
        tx_eof_net  = g0 ? s0_tx_eof  : g1 & s1_tx_eof;
        tx_vld_net  = g0 ? s0_tx_vld  : g1 & s1_tx_vld;
        s0_tx_ack   = g0 & tx_ack_net;
        s1_tx_ack   = g1 & tx_ack_net;
    end

    always_ff @(posedge clk_net or posedge rst)
        if (rst)                               last_gnt <= 1'b1;
        else if (state == IDLE && nxt != IDLE) last_gnt <= nxt == GNT1;

    // Token bucket: wide signed arithmetic so rate/burst/debit never wrap before clamping.
    assign per_m1  = (cfg_period == '0) ? '0 : cfg_period - 32'd1;
    assign tick    = pcnt >= per_m1;
    assign debit   = (s0_tx_eof && s0_tx_len != '0) ? {1'b0, s0_tx_len} : (LW+1)'(WIDTH/8);
    assign burst_x = EW'(cfg_burst);

    always_comb begin
        acc      = EW'(credit) + (tick ? EW'(cfg_rate) : '0) - (a0 ? EW'(debit) : '0);
        capped   = (tick && acc > burst_x) ? burst_x : acc;
        credit_d = !cfg_en ? ((burst_x > CMAX) ? CMAX : burst_x)
                 : (capped < CMIN) ? CMIN : (capped > CMAX) ? CMAX : capped;
    end

    always_ff @(posedge clk_net or posedge rst)
        if (rst) begin
            credit <= '0;
            pcnt   <= '0;
        end else begin
            credit <= CREDIT_W'(credit_d);
            pcnt   <= tick ? '0 : pcnt + 32'd1;
        end

    always_ff @(posedge clk_net or posedge rst)
        if (rst) begin
            fcnt0 <= '0;
            fcnt1 <= '0;
        end else begin
            if (a0 & s0_tx_eof) fcnt0 <= fcnt0 + 32'd1;
            if (a1 & s1_tx_eof) fcnt1 <= fcnt1 + 32'd1;
        end

    assign woff = reg_w_addr - 11'(BASE_ADDR);
    assign roff = reg_r_addr - 11'(BASE_ADDR);

    always_comb begin
        rmux = '0;
        case (roff[2:0])
            3'd0:    rmux = {30'd0, cfg_prio, cfg_en};
            3'd1:    rmux = cfg_rate;
            3'd2:    rmux = cfg_period;
            3'd3:    rmux = cfg_burst;
            3'd4:    rmux = 32'(credit);
            3'd5:    rmux = fcnt0;
            3'd6:    rmux = fcnt1;
            default: rmux = '0;
        endcase
    end

    always_ff @(posedge clk_net or posedge rst)
        if (rst) begin
            {cfg_en, cfg_prio} <= '0;
            cfg_rate   <= '0;
            cfg_period <= '0;
            cfg_burst  <= '0;
            reg_r_data <= '0;
            reg_r_ack  <= 1'b0;
        end else begin
            if (reg_w_en && woff == 11'd0) {cfg_prio, cfg_en} <= reg_w_data[1:0];
            if (reg_w_en && woff == 11'd1) cfg_rate   <= reg_w_data;
            if (reg_w_en && woff == 11'd2) cfg_period <= reg_w_data;
            if (reg_w_en && woff == 11'd3) cfg_burst  <= reg_w_data;
            reg_r_ack <= reg_r_en && roff < 11'd7;
            if (reg_r_en && roff < 11'd7) reg_r_data <= rmux;
        end
endmodule
